pal_cfg_loader: RTL and testbench
=================================

// Module: pal_cfg_loader
// PURPOSE
//  Drives the PAL configuration chain: accepts config bytes over a valid/ready handshake and
//  serialises them LSB-first onto cfg_out with a generated cfg_clk and cfg_en.
//  Sits between the host-side config source and the PAL cfg/clk/en pins.
//  Counts exactly CFG_BITS bits per load, then reports done.
// PARAMETERS
//  CFG_BITS  200  total chain length (2*N*P + P*M for N=8, P=10, M=4)
//  CLK_DIV   2    clk cycles per cfg_clk half-period (>=1)
// PORTS
//  clk         in   1   system clock; all state on rising edge
//  res_n       in   1   asynchronous active-low reset
//  start       in   1   1-cycle pulse: begin a load (ignored unless IDLE or DONE)
//  abort       in   1   1-cycle pulse: cancel the load, return to IDLE
//  byte_data   in   8   config byte; bit 0 is shifted first
//  byte_valid  in   1   byte_data valid
//  byte_ready  out  1   loader accepts byte_data this cycle
//  cfg_clk     out  1   chain shift clock; cfg_out is stable across its rising edge
//  cfg_en      out  1   chain shift enable; high for the whole active load
//  cfg_out     out  1   serial config bit
//  busy        out  1   load in progress
//  done        out  1   high from completion until the next start or abort
//  bit_count   out  $clog2(CFG_BITS+1)  bits shifted in the current load
// BEHAVIOUR
//  Reset: state=IDLE; byte_ready, cfg_clk, cfg_en, cfg_out, busy, done = 0; bit_count = 0.
//  FSM states: IDLE, FETCH, SHIFT_LO, SHIFT_HI, DONE.
//  IDLE/DONE + start: clear bit_count, clear done, set busy and cfg_en, go to FETCH.
//  FETCH: byte_ready = 1. On byte_valid & byte_ready:
//   - load the shift register and set bits_left = min(8, CFG_BITS - bit_count);
//   - drive cfg_out = byte_data[0] on the next cycle;
//   - go to SHIFT_LO.
//  SHIFT_LO: cfg_clk = 0 for CLK_DIV cycles, then go to SHIFT_HI.
//  SHIFT_HI: cfg_clk = 1 for CLK_DIV cycles. On exit:
//   - bit_count++, bits_left--, shift register >> 1;
//   - if bit_count == CFG_BITS, go to DONE;
//   - else if bits_left == 0, go to FETCH;
//   - else drive cfg_out = next bit and go to SHIFT_LO.
//  Bit timing: each bit costs 2*CLK_DIV cycles. A byte boundary adds exactly one FETCH cycle
//   when byte_valid is already high. cfg_clk stays 0 in FETCH, so stalls are unbounded and safe.
//  Final partial byte: only the remaining CFG_BITS mod 8 bits are shifted; upper bits are discarded.
//  DONE: cfg_en = 0, cfg_clk = 0, busy = 0, done = 1. bit_count holds CFG_BITS.
//  abort (any state): next cycle IDLE with cfg_en = 0, cfg_clk = 0, busy = 0, done = 0.
//   bit_count holds its value for debug. abort has priority over start and byte acceptance.
//  start while busy: ignored.
//  byte_valid outside FETCH: ignored; byte_ready = 0 there.
//  Reset mid-load: immediate return to reset values. The chain contents are undefined and a new
//   full load is required.
//  cfg_clk, cfg_en and cfg_out are registered outputs: no combinational path from any input.
// STRUCTURE
//  Package pal_cfg_pkg:
//   - state enum;
//   - CFG_BITS default formula as a localparam function of N, P, M, shared with the PAL top.
//  Sub-module pal_cfg_clkgen: CLK_DIV half-period counter with a phase_end strobe,
//   reset by the FSM on every FETCH->SHIFT_LO transition.
//  Shift register, bit counters and FSM stay in pal_cfg_loader.
// TESTING
//  1. Reset with all inputs 0 -> every output 0, byte_ready = 0; stays so for 20 cycles.
//  2. CFG_BITS=16, CLK_DIV=2, start, bytes 0xA5 then 0x3C always valid:
//     - cfg_out at the 16 cfg_clk rises = 1,0,1,0,0,1,0,1, 0,0,1,1,1,1,0,0;
//     - done after 16*4 + 2 FETCH cycles.
//  3. CFG_BITS=12, bytes 0xFF, 0x0F:
//     - exactly 12 cfg_clk rises, the last 4 bits = 1;
//     - bit_count = 12, done = 1.
//  4. byte_valid withheld 10 cycles in FETCH -> cfg_clk stays 0, byte_ready stays 1, no bit lost.
//  5. abort after 5 bits -> next cycle IDLE: cfg_en = 0, busy = 0, bit_count = 5;
//     a following start reloads from bit_count = 0.
//  6. start while busy (bit 3 of 200) -> ignored; default CFG_BITS=200 load completes
//     with 200 rises and 25 handshakes.

Source files
------------

// File: rtl/pal_cfg_pkg.sv
// Shared types and chain-length constants for the PAL configuration loader.
package pal_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SHIFT_LO,
    ST_SHIFT_HI,
    ST_DONE
  } state_e;

  function automatic int cfg_bits_calc(input int n, input int p, input int m);
    return 2 * n * p + p * m;
  endfunction

  localparam int PAL_N        = 8;
  localparam int PAL_P        = 10;
  localparam int PAL_M        = 4;
  localparam int CFG_BITS_DEF = cfg_bits_calc(PAL_N, PAL_P, PAL_M);

endpackage

// File: rtl/pal_cfg_clkgen.sv
// Half-period timer for cfg_clk: down-counter reloaded on terminal count or on clear.
module pal_cfg_clkgen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic res_n,
  input  logic clr_i,
  input  logic en_i,
  output logic phase_end_o
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q;

  assign phase_end_o = en_i && (cnt_q == '0);

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      cnt_q <= RELOAD;
    end else if (clr_i || phase_end_o) begin
      cnt_q <= RELOAD;
    end else if (en_i) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/pal_cfg_loader.sv
// Serialises handshaked config bytes LSB-first onto the PAL cfg chain with cfg_clk/cfg_en.
//   state    | meaning
//   IDLE     | no load; waits for start
//   FETCH    | byte_ready high, cfg_clk low; waits for a byte
//   SHIFT_LO | cfg_clk low, cfg_out settling, CLK_DIV cycles
//   SHIFT_HI | cfg_clk high, chain samples cfg_out, CLK_DIV cycles
//   DONE     | CFG_BITS shifted; done high until start or abort
module pal_cfg_loader
  import pal_cfg_pkg::*;
#(
  parameter int CFG_BITS = CFG_BITS_DEF,
  parameter int CLK_DIV  = 2
) (
  input  logic                              clk,
  input  logic                              res_n,
  input  logic                              start,
  input  logic                              abort,
  input  logic [7:0]                        byte_data,
  input  logic                              byte_valid,
  output logic                              byte_ready,
  output logic                              cfg_clk,
  output logic                              cfg_en,
  output logic                              cfg_out,
  output logic                              busy,
  output logic                              done,
  output logic [$clog2(CFG_BITS+1)-1:0]     bit_count
);

  localparam int BCW = $clog2(CFG_BITS + 1);

  state_e         state_q;
  logic [7:0]     sreg_q;
  logic [3:0]     bits_left_q;
  logic [BCW-1:0] bit_count_q;
  logic           byte_ready_q;
  logic           cfg_clk_q;
  logic           cfg_en_q;
  logic           cfg_out_q;
  logic           busy_q;
  logic           done_q;

  logic           accept;
  logic           phase_end;
  logic           shifting;
  logic           last_bit;
  int             rem_bits;
  logic [3:0]     load_len;

  assign accept   = (state_q == ST_FETCH) && byte_valid && !abort;
  assign shifting = (state_q == ST_SHIFT_LO) || (state_q == ST_SHIFT_HI);
  assign last_bit = (bit_count_q == BCW'(CFG_BITS - 1));

  // The final byte of a chain that is not a multiple of 8 only contributes its low bits.
  always_comb begin
    rem_bits = CFG_BITS - int'(bit_count_q);
    load_len = 4'd8;
    if (rem_bits < 8) load_len = 4'(rem_bits);
  end

  pal_cfg_clkgen #(
    .CLK_DIV (CLK_DIV)
  ) u_clkgen (
    .clk         (clk),
    .res_n       (res_n),
    .clr_i       (accept),
    .en_i        (shifting),
    .phase_end_o (phase_end)
  );

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_q      <= ST_IDLE;
      sreg_q       <= '0;
      bits_left_q  <= '0;
      bit_count_q  <= '0;
      byte_ready_q <= 1'b0;
      cfg_clk_q    <= 1'b0;
      cfg_en_q     <= 1'b0;
      cfg_out_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else if (abort) begin
      state_q      <= ST_IDLE;
      byte_ready_q <= 1'b0;
      cfg_clk_q    <= 1'b0;
      cfg_en_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            bit_count_q  <= '0;
            done_q       <= 1'b0;
            busy_q       <= 1'b1;
            cfg_en_q     <= 1'b1;
            byte_ready_q <= 1'b1;
            state_q      <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (byte_valid) begin
            sreg_q       <= byte_data;
            bits_left_q  <= load_len;
            cfg_out_q    <= byte_data[0];
            byte_ready_q <= 1'b0;
            state_q      <= ST_SHIFT_LO;
          end
        end
        ST_SHIFT_LO: begin
          if (phase_end) begin
            cfg_clk_q <= 1'b1;
            state_q   <= ST_SHIFT_HI;
          end
        end
        ST_SHIFT_HI: begin
          if (phase_end) begin
            cfg_clk_q   <= 1'b0;
            bit_count_q <= bit_count_q + 1'b1;
            bits_left_q <= bits_left_q - 1'b1;
            sreg_q      <= sreg_q >> 1;
            if (last_bit) begin
              cfg_en_q <= 1'b0;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
              state_q  <= ST_DONE;
            end else if (bits_left_q == 4'd1) begin
              byte_ready_q <= 1'b1;
              state_q      <= ST_FETCH;
            end else begin
              cfg_out_q <= sreg_q[1];
              state_q   <= ST_SHIFT_LO;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign byte_ready = byte_ready_q;
  assign cfg_clk    = cfg_clk_q;
  assign cfg_en     = cfg_en_q;
  assign cfg_out    = cfg_out_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign bit_count  = bit_count_q;

endmodule

// File: tb/tb_pal_cfg_loader.sv
// Self-checking bench for pal_cfg_loader: three instances (16, 12 and default 200 chain bits).
module tb_pal_cfg_loader;

  logic       clk = 1'b0;
  logic       res_n = 1'b0;
  logic       abort = 1'b0;
  logic       byte_valid = 1'b0;
  logic [7:0] byte_data = 8'h00;
  logic [2:0] start_w = 3'b000;

  logic [2:0] rdy_w, cclk_w, en_w, out_w, busy_w, done_w;
  logic [4:0] bc0;
  logic [3:0] bc1;
  logic [7:0] bc2;
  int         bc_w[3];

  assign bc_w[0] = int'(bc0);
  assign bc_w[1] = int'(bc1);
  assign bc_w[2] = int'(bc2);

  always #5 clk = ~clk;

  pal_cfg_loader #(.CFG_BITS(16), .CLK_DIV(2)) u16 (
    .clk(clk), .res_n(res_n), .start(start_w[0]), .abort(abort),
    .byte_data(byte_data), .byte_valid(byte_valid), .byte_ready(rdy_w[0]),
    .cfg_clk(cclk_w[0]), .cfg_en(en_w[0]), .cfg_out(out_w[0]),
    .busy(busy_w[0]), .done(done_w[0]), .bit_count(bc0));

  pal_cfg_loader #(.CFG_BITS(12), .CLK_DIV(2)) u12 (
    .clk(clk), .res_n(res_n), .start(start_w[1]), .abort(abort),
    .byte_data(byte_data), .byte_valid(byte_valid), .byte_ready(rdy_w[1]),
    .cfg_clk(cclk_w[1]), .cfg_en(en_w[1]), .cfg_out(out_w[1]),
    .busy(busy_w[1]), .done(done_w[1]), .bit_count(bc1));

  pal_cfg_loader #(.CLK_DIV(2)) u200 (
    .clk(clk), .res_n(res_n), .start(start_w[2]), .abort(abort),
    .byte_data(byte_data), .byte_valid(byte_valid), .byte_ready(rdy_w[2]),
    .cfg_clk(cclk_w[2]), .cfg_en(en_w[2]), .cfg_out(out_w[2]),
    .busy(busy_w[2]), .done(done_w[2]), .bit_count(bc2));

  // Chain-side monitor: captures cfg_out at each cfg_clk rise, counts handshakes.
  logic [255:0] cap[3];
  int           rises[3];
  int           hs[3];
  logic [2:0]   prev_clk = 3'b000;
  logic         mon_clr = 1'b0;

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (mon_clr) begin
        cap[k]   = '0;
        rises[k] = 0;
        hs[k]    = 0;
      end else begin
        if (cclk_w[k] && !prev_clk[k]) begin
          if (rises[k] < 256) cap[k][rises[k]] = out_w[k];
          rises[k]++;
        end
        if (byte_valid && rdy_w[k] && !abort) hs[k]++;
      end
    end
    prev_clk = cclk_w;
  end

  // Host-side source: presents the next byte after each accepted one.
  logic [7:0] feed_bytes[32];
  int         feed_idx = 0;
  int         sel = 0;

  always @(posedge clk) begin
    if (byte_valid && rdy_w[sel] && !abort) begin
      #1;
      if (feed_idx < 31) feed_idx++;
      byte_data = feed_bytes[feed_idx];
    end
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: actual %0d required %0d", name, act, exp);
  endtask

  task automatic clear_mon();
    mon_clr = 1'b1;
    @(negedge clk);
    #1 mon_clr = 1'b0;
  endtask

  task automatic setup_feed(input int k, input logic [7:0] b0, input logic [7:0] b1);
    sel = k;
    for (int i = 0; i < 32; i++) feed_bytes[i] = 8'h00;
    feed_bytes[0] = b0;
    feed_bytes[1] = b1;
    feed_idx  = 0;
    byte_data = b0;
  endtask

  task automatic start_pulse(input int k);
    @(posedge clk);
    #1 start_w[k] = 1'b1;
    @(posedge clk);
    #1 start_w[k] = 1'b0;
  endtask

  task automatic wait_done(input int k, output int cyc);
    int n;
    n = 0;
    while (!done_w[k] && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    cyc = n;
  endtask

  typedef struct {
    int          k;
    logic [7:0]  b0;
    logic [7:0]  b1;
    int          exp_rises;
    logic [15:0] exp_bits;
    int          exp_cyc;
    int          exp_bc;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int cyc;
    int bad;
    int nmis;

    vecs[0] = '{0, 8'hA5, 8'h3C, 16, 16'h3CA5, 66, 16};
    vecs[1] = '{1, 8'hFF, 8'h0F, 12, 16'h0FFF, 50, 12};
    vecs[2] = '{0, 8'h00, 8'hFF, 16, 16'hFF00, 66, 16};
    vecs[3] = '{1, 8'h5A, 8'hF3, 12, 16'h035A, 50, 12};

    // Reset state, held quiet for 20 cycles after release.
    repeat (3) @(posedge clk);
    #1;
    chk("in_reset_outputs", {rdy_w, cclk_w, en_w, out_w, busy_w, done_w}, 0);
    res_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      chk("idle_outputs", {rdy_w, cclk_w, en_w, out_w, busy_w, done_w,
                           bc0, bc1, bc2}, 0);
    end

    // Table-driven full loads with continuous byte_valid.
    byte_valid = 1'b1;
    for (int v = 0; v < 4; v++) begin
      setup_feed(vecs[v].k, vecs[v].b0, vecs[v].b1);
      clear_mon();
      start_pulse(vecs[v].k);
      wait_done(vecs[v].k, cyc);
      chk($sformatf("v%0d_cycles", v), cyc, vecs[v].exp_cyc);
      chk($sformatf("v%0d_rises", v), rises[vecs[v].k], vecs[v].exp_rises);
      chk($sformatf("v%0d_bits", v), cap[vecs[v].k][15:0], vecs[v].exp_bits);
      chk($sformatf("v%0d_handshakes", v), hs[vecs[v].k], 2);
      chk($sformatf("v%0d_bit_count", v), bc_w[vecs[v].k], vecs[v].exp_bc);
      chk($sformatf("v%0d_done_busy_en", v),
          {done_w[vecs[v].k], busy_w[vecs[v].k], en_w[vecs[v].k], cclk_w[vecs[v].k]}, 4'b1000);
    end

    // Stall in FETCH: cfg_clk stays low, byte_ready stays high, nothing lost.
    byte_valid = 1'b0;
    setup_feed(0, 8'hA5, 8'h3C);
    clear_mon();
    start_pulse(0);
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      if (cclk_w[0] || !rdy_w[0] || !en_w[0]) bad++;
    end
    chk("stall_bad_cycles", bad, 0);
    chk("stall_no_rises", rises[0], 0);
    byte_valid = 1'b1;
    wait_done(0, cyc);
    chk("stall_done", done_w[0], 1);
    chk("stall_rises", rises[0], 16);
    chk("stall_bits", cap[0][15:0], 16'h3CA5);

    // Abort after 5 bits, then a fresh load from bit_count 0.
    setup_feed(0, 8'hA5, 8'h3C);
    clear_mon();
    start_pulse(0);
    cyc = 0;
    while (bc_w[0] != 5 && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("abort_reach5", bc_w[0], 5);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    chk("abort_outputs", {busy_w[0], en_w[0], cclk_w[0], rdy_w[0], done_w[0]}, 0);
    chk("abort_bit_count", bc_w[0], 5);
    chk("abort_rises", rises[0], 5);
    repeat (3) @(posedge clk);
    #1;
    chk("abort_stays_idle", {busy_w[0], en_w[0], rdy_w[0]}, 0);
    setup_feed(0, 8'hA5, 8'h3C);
    clear_mon();
    start_pulse(0);
    chk("restart_bit_count", bc_w[0], 0);
    chk("restart_busy_en", {busy_w[0], en_w[0]}, 2'b11);
    wait_done(0, cyc);
    chk("restart_rises", rises[0], 16);
    chk("restart_bits", cap[0][15:0], 16'h3CA5);

    // Default 200-bit chain with a stray start mid-load.
    sel = 2;
    for (int i = 0; i < 32; i++) feed_bytes[i] = 8'((i * 29 + 7) ^ (i << 4));
    feed_idx  = 0;
    byte_data = feed_bytes[0];
    clear_mon();
    start_pulse(2);
    cyc = 0;
    while (bc_w[2] != 3 && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("long_reach3", bc_w[2], 3);
    start_w[2] = 1'b1;
    @(posedge clk);
    #1 start_w[2] = 1'b0;
    chk("long_start_ignored_bc", bc_w[2], 3);
    chk("long_start_ignored_busy", {busy_w[2], done_w[2]}, 2'b10);
    wait_done(2, cyc);
    chk("long_done", done_w[2], 1);
    chk("long_bit_count", bc_w[2], 200);
    chk("long_rises", rises[2], 200);
    chk("long_handshakes", hs[2], 25);
    nmis = 0;
    for (int j = 0; j < 200; j++) begin
      if (cap[2][j] !== feed_bytes[j / 8][j % 8]) nmis++;
    end
    chk("long_bit_errors", nmis, 0);

    byte_valid = 1'b0;
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
